display_bus_scheduler: RTL and testbench

Sequences the 8080-style display bus. It merges a host command channel and a framebuffer pixel stream into one ordered stream of {dc, byte} bus entries for the downstream byte serializer. Command packets are only admitted between frames. Every pixel frame is preceded by an address-window preamble (column set, page set, memory write), and each RGB565 pixel is split into high and low bytes.

---
 rtl/display_pkg.sv | 33 +++
 rtl/display_bus_scheduler_if.sv | 12 +
 rtl/display_window_rom.sv | 29 ++
 rtl/display_bus_scheduler.sv | 141 ++++++++++++++
 tb/tb_display_bus_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display bus scheduler.
// DISPLAY_SCHED_WINDOW_EN selects the full 11-entry window preamble; otherwise only RAMWR is emitted.
package display_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } bus_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WIN,
    PIX_HI,
    PIX_LO
  } state_t;

`ifdef DISPLAY_SCHED_WINDOW_EN
  localparam int PREAMBLE_LEN = 11;
`else
  localparam int PREAMBLE_LEN = 1;
`endif

  // The preamble always ends on the RAMWR slot of the window ROM, so a short
  // preamble simply starts further into the table.
  localparam logic [3:0] WIN_LAST_IDX  = 4'd10;
  localparam logic [3:0] WIN_FIRST_IDX = 4'(11 - PREAMBLE_LEN);

endpackage

// File: rtl/display_bus_scheduler_if.sv
// Valid/ready stream bundle used for the command, pixel and bus-entry channels.
interface display_bus_scheduler_if #(
  parameter int DATA_W = 9
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/display_window_rom.sv
// Address-window preamble table: CASET/PASET with full-screen bounds, then RAMWR.
module display_window_rom
  import display_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic [3:0] win_idx,
  output bus_entry_t entry
);

  localparam logic [15:0] W_END = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] H_END = 16'(SCREEN_HEIGHT - 1);

  always_comb begin
    case (win_idx)
      4'd0:       entry = '{dc: 1'b0, data: CMD_CASET};
      4'd1, 4'd2: entry = '{dc: 1'b1, data: 8'h00};
      4'd3:       entry = '{dc: 1'b1, data: W_END[15:8]};
      4'd4:       entry = '{dc: 1'b1, data: W_END[7:0]};
      4'd5:       entry = '{dc: 1'b0, data: CMD_PASET};
      4'd6, 4'd7: entry = '{dc: 1'b1, data: 8'h00};
      4'd8:       entry = '{dc: 1'b1, data: H_END[15:8]};
      4'd9:       entry = '{dc: 1'b1, data: H_END[7:0]};
      default:    entry = '{dc: 1'b0, data: CMD_RAMWR};
    endcase
  end

endmodule

// File: rtl/display_bus_scheduler.sv
// Merges host command packets and framebuffer pixels into one {dc, byte} bus stream.
// DISPLAY_SCHED_WINDOW_EN (in display_pkg) enables the full window preamble before each frame.
module display_bus_scheduler
  import display_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                           aclk,
  input  logic                           resetn,
  display_bus_scheduler_if.slave         s_cmd,
  display_bus_scheduler_if.slave         s_pix,
  display_bus_scheduler_if.master        m_axis,
  output logic                           busy,
  output logic                           frame_err
);

  localparam logic [31:0] FRAME_PIX = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);

  state_t      state_q, state_d;
  logic [3:0]  win_idx_q, win_idx_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]  pix_lo_q, pix_lo_d;
  logic        pix_last_q, pix_last_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  bus_entry_t  m_data_q, m_data_d;
  logic        frame_err_q, frame_err_d;
  bus_entry_t  win_entry;
  logic        slot_free;

  display_window_rom #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT)
  ) u_window_rom (
    .win_idx (win_idx_q),
    .entry   (win_entry)
  );

  assign slot_free     = !m_valid_q || m_axis.tready;
  assign s_cmd.tready  = (state_q == CMD) && slot_free;
  assign s_pix.tready  = (state_q == PIX_HI) && slot_free;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign busy          = (state_q != IDLE);
  assign frame_err     = frame_err_q;

  always_comb begin
    state_d     = state_q;
    win_idx_d   = win_idx_q;
    pix_cnt_d   = pix_cnt_q;
    pix_lo_d    = pix_lo_q;
    pix_last_d  = pix_last_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_err_d = 1'b0;
    // A draining slot empties unless this cycle loads a new entry.
    if (slot_free) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_cmd.tvalid) begin
          state_d = CMD;
        end else if (s_pix.tvalid) begin
          state_d   = WIN;
          win_idx_d = WIN_FIRST_IDX;
          pix_cnt_d = '0;
        end
      end
      CMD: begin
        if (slot_free && s_cmd.tvalid) begin
          m_valid_d = 1'b1;
          m_data_d  = bus_entry_t'(s_cmd.tdata);
          m_last_d  = s_cmd.tlast;
          if (s_cmd.tlast) state_d = IDLE;
        end
      end
      WIN: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = win_entry;
          m_last_d  = 1'b0;
          if (win_idx_q == WIN_LAST_IDX) state_d = PIX_HI;
          else                           win_idx_d = win_idx_q + 4'd1;
        end
      end
      PIX_HI: begin
        if (slot_free && s_pix.tvalid) begin
          pix_lo_d   = s_pix.tdata[7:0];
          pix_last_d = s_pix.tlast;
          m_valid_d  = 1'b1;
          m_data_d   = '{dc: 1'b1, data: s_pix.tdata[15:8]};
          m_last_d   = 1'b0;
          pix_cnt_d  = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 32'd1;
          state_d    = PIX_LO;
        end
      end
      PIX_LO: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = '{dc: 1'b1, data: pix_lo_q};
          m_last_d  = pix_last_q;
          if (pix_last_q) begin
            state_d     = IDLE;
            frame_err_d = (pix_cnt_q != FRAME_PIX);
          end else begin
            state_d = PIX_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      win_idx_q   <= '0;
      pix_cnt_q   <= '0;
      pix_lo_q    <= '0;
      pix_last_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_idx_q   <= win_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      pix_lo_q    <= pix_lo_d;
      pix_last_q  <= pix_last_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_display_bus_scheduler.sv
// Directed bench: a 320x480 scheduler plus an 8x4 one sharing the same stimulus for full-frame runs.
module tb_display_bus_scheduler;
  import display_pkg::*;

`ifdef DISPLAY_SCHED_WINDOW_EN
  localparam int PRE_FIRST = 0;
`else
  localparam int PRE_FIRST = 10;
`endif

  logic aclk   = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid = 1'b0, cmd_last = 1'b0;
  logic [8:0]  cmd_data  = '0;
  logic        pix_valid = 1'b0, pix_last = 1'b0;
  logic [15:0] pix_data  = '0;
  logic        m_ready   = 1'b1;
  logic        stall_en  = 1'b0;
  logic        sel_small = 1'b0;
  logic        busy_a, busy_b, ferr_a, ferr_b;

  display_bus_scheduler_if #(.DATA_W(9))  cmd_a ();
  display_bus_scheduler_if #(.DATA_W(9))  cmd_b ();
  display_bus_scheduler_if #(.DATA_W(16)) pix_a ();
  display_bus_scheduler_if #(.DATA_W(16)) pix_b ();
  display_bus_scheduler_if #(.DATA_W(9))  m_a ();
  display_bus_scheduler_if #(.DATA_W(9))  m_b ();

  assign cmd_a.tvalid = cmd_valid;
  assign cmd_a.tdata  = cmd_data;
  assign cmd_a.tlast  = cmd_last;
  assign cmd_b.tvalid = cmd_valid;
  assign cmd_b.tdata  = cmd_data;
  assign cmd_b.tlast  = cmd_last;
  assign pix_a.tvalid = pix_valid;
  assign pix_a.tdata  = pix_data;
  assign pix_a.tlast  = pix_last;
  assign pix_b.tvalid = pix_valid;
  assign pix_b.tdata  = pix_data;
  assign pix_b.tlast  = pix_last;
  assign m_a.tready   = m_ready;
  assign m_b.tready   = m_ready;

  display_bus_scheduler #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(480)) dut (
    .aclk      (aclk),
    .resetn    (resetn),
    .s_cmd     (cmd_a.slave),
    .s_pix     (pix_a.slave),
    .m_axis    (m_a.master),
    .busy      (busy_a),
    .frame_err (ferr_a)
  );

  display_bus_scheduler #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4)) dut_small (
    .aclk      (aclk),
    .resetn    (resetn),
    .s_cmd     (cmd_b.slave),
    .s_pix     (pix_b.slave),
    .m_axis    (m_b.master),
    .busy      (busy_b),
    .frame_err (ferr_b)
  );

  logic       o_valid, o_last, o_cmd_rdy, o_pix_rdy, o_ferr;
  logic [8:0] o_data;
  assign o_valid   = sel_small ? m_b.tvalid   : m_a.tvalid;
  assign o_last    = sel_small ? m_b.tlast    : m_a.tlast;
  assign o_data    = sel_small ? m_b.tdata    : m_a.tdata;
  assign o_cmd_rdy = sel_small ? cmd_b.tready : cmd_a.tready;
  assign o_pix_rdy = sel_small ? pix_b.tready : pix_a.tready;
  assign o_ferr    = sel_small ? ferr_b       : ferr_a;

  always @(posedge aclk) begin
    #1;
    m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output collector: {tlast, dc, byte} per handshake, plus stall stability and event counters.
  logic [9:0] got_q[$];
  int         ferr_cnt = 0, stab_err = 0, cmd_early = 0;
  logic       in_frame = 1'b0, prev_stall = 1'b0;
  logic [9:0] prev_ent = '0;

  always @(negedge aclk) begin
    if (!resetn) begin
      prev_stall <= 1'b0;
      in_frame   <= 1'b0;
    end else begin
      if (prev_stall && (!o_valid || {o_last, o_data} != prev_ent)) stab_err <= stab_err + 1;
      prev_stall <= o_valid && !m_ready;
      prev_ent   <= {o_last, o_data};
      if (o_ferr) ferr_cnt <= ferr_cnt + 1;
      if (in_frame && o_cmd_rdy) cmd_early <= cmd_early + 1;
      if (o_valid && m_ready) begin
        got_q.push_back({o_last, o_data});
        if (o_data == {1'b0, CMD_RAMWR}) in_frame <= 1'b1;
        else if (o_last && o_data[8])   in_frame <= 1'b0;
      end
    end
  end

  int         checks = 0, errors = 0;
  int         got_base = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, int'(m_a.tvalid), 0);
    chk({tag, "_tdata"},  int'(m_a.tdata), 0);
    chk({tag, "_tlast"},  int'(m_a.tlast), 0);
    chk({tag, "_cmd_rdy"}, int'(cmd_a.tready), 0);
    chk({tag, "_pix_rdy"}, int'(pix_a.tready), 0);
    chk({tag, "_busy"},   int'(busy_a), 0);
    chk({tag, "_ferr"},   int'(ferr_a), 0);
  endtask

  task automatic exp_cmd(input logic [8:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic exp_pix(input logic [15:0] p, input logic l);
    exp_q.push_back({2'b01, p[15:8]});
    exp_q.push_back({l, 1'b1, p[7:0]});
  endtask

  task automatic exp_preamble(input logic [15:0] w_end, input logic [15:0] h_end);
    logic [9:0] pre [11];
    pre = '{{2'b00, 8'h2A}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, w_end[15:8]}, {2'b01, w_end[7:0]},
            {2'b00, 8'h2B}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, h_end[15:8]}, {2'b01, h_end[7:0]},
            {2'b00, 8'h2C}};
    for (int i = PRE_FIRST; i < 11; i++) exp_q.push_back(pre[i]);
  endtask

  task automatic send_cmd(input logic [8:0] d, input logic l);
    int n = 0;
    cmd_data = d; cmd_last = l; cmd_valid = 1'b1;
    @(negedge aclk);
    while (!o_cmd_rdy && n < 1000) begin @(negedge aclk); n++; end
    if (n >= 1000) chk("cmd_hs_timeout", n, 0);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d, input logic l);
    int n = 0;
    pix_data = d; pix_last = l; pix_valid = 1'b1;
    @(negedge aclk);
    while (!o_pix_rdy && n < 1000) begin @(negedge aclk); n++; end
    if (n >= 1000) chk("pix_hs_timeout", n, 0);
    @(posedge aclk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int npix, input logic [15:0] base);
    for (int i = 0; i < npix; i++) exp_pix(base + 16'(i) * 16'h0421, i == npix - 1);
    for (int i = 0; i < npix; i++) send_pix(base + 16'(i) * 16'h0421, i == npix - 1);
  endtask

  task automatic cmp_stream(input string tag);
    int n = 0;
    while (got_q.size() < got_base + exp_q.size() && n < 5000) begin @(negedge aclk); n++; end
    repeat (4) @(negedge aclk);
    chk({tag, "_len"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (got_base + i < got_q.size()) chk(tag, int'(got_q[got_base + i]), int'(exp_q[i]));
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int f0, s0, c0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset("rst");
    @(posedge aclk); #1;
    resetn = 1'b1;

    exp_cmd(9'h011, 1'b0);
    exp_cmd(9'h029, 1'b1);
    send_cmd(9'h011, 1'b0);
    send_cmd(9'h029, 1'b1);
    cmp_stream("cmd_pkt");
    chk("cmd_busy_after", int'(busy_a), 0);

    f0 = ferr_cnt;
    exp_preamble(16'h013F, 16'h01DF);
    exp_pix(16'hF81F, 1'b0);
    exp_pix(16'h07E0, 1'b1);
    send_pix(16'hF81F, 1'b0);
    send_pix(16'h07E0, 1'b1);
    cmp_stream("frame2");
    chk("frame2_err_pulses", ferr_cnt - f0, 1);

    f0 = ferr_cnt;
    exp_cmd(9'h011, 1'b0);
    exp_cmd(9'h029, 1'b1);
    exp_preamble(16'h013F, 16'h01DF);
    exp_pix(16'hF81F, 1'b0);
    exp_pix(16'h07E0, 1'b1);
    fork
      begin send_cmd(9'h011, 1'b0); send_cmd(9'h029, 1'b1); end
      begin send_pix(16'hF81F, 1'b0); send_pix(16'h07E0, 1'b1); end
    join
    cmp_stream("cmd_wins");
    chk("cmd_wins_err_pulses", ferr_cnt - f0, 1);

    f0 = ferr_cnt;
    c0 = cmd_early;
    exp_preamble(16'h013F, 16'h01DF);
    exp_pix(16'h1234, 1'b0);
    exp_pix(16'hABCD, 1'b0);
    exp_pix(16'h0001, 1'b1);
    exp_cmd(9'h03A, 1'b1);
    fork
      begin send_pix(16'h1234, 1'b0); send_pix(16'hABCD, 1'b0); send_pix(16'h0001, 1'b1); end
      begin
        int n = 0;
        while (!in_frame && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) chk("in_frame_timeout", n, 0);
        @(posedge aclk); #1;
        send_cmd(9'h03A, 1'b1);
      end
    join
    cmp_stream("mid_frame_cmd");
    chk("mid_frame_cmd_rdy_early", cmd_early - c0, 0);
    chk("mid_frame_err_pulses", ferr_cnt - f0, 1);

    sel_small = 1'b1;
    f0 = ferr_cnt;
    exp_preamble(16'h0007, 16'h0003);
    run_frame(31, 16'h1000);
    cmp_stream("short_frame");
    chk("short_frame_err_pulses", ferr_cnt - f0, 1);

    f0 = ferr_cnt;
    s0 = stab_err;
    stall_en = 1'b1;
    exp_preamble(16'h0007, 16'h0003);
    run_frame(32, 16'h8421);
    cmp_stream("stall_frame");
    stall_en = 1'b0;
    chk("stall_frame_err_pulses", ferr_cnt - f0, 0);
    chk("stall_tdata_stable", stab_err - s0, 0);

    sel_small = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    send_pix(16'h5555, 1'b0);
    chk("busy_mid_frame", int'(busy_a), 1);
    resetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk_reset("rst_pix_lo");
    @(posedge aclk); #1;
    resetn = 1'b1;
    got_base = got_q.size();
    f0 = ferr_cnt;
    exp_preamble(16'h013F, 16'h01DF);
    exp_pix(16'hA5C3, 1'b1);
    send_pix(16'hA5C3, 1'b1);
    cmp_stream("after_reset");
    chk("after_reset_err_pulses", ferr_cnt - f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
